rv32_seq_ctrl: RTL and testbench
================================

# rv32_seq_ctrl

Multi-cycle sequencer for the RV32I integer datapath. It fetches one instruction at a time over a req/ack instruction-memory port and decodes OP and OP-IMM instructions into register-file addresses, an immediate and the 4-bit ALU control code. It then captures the ALU result and issues a single register-file write. It sits between instruction memory, the register file and the combinational ALU, and owns the PC and the retire counter.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk_i  in  1  clock; all state changes on rising edge
- res_i  in  1  reset, asynchronous, active-high
- run_i  in  1  1 = allow a new fetch; sampled in IDLE and WB
- imem_req_o  out  1  fetch request; held until ack
- imem_addr_o  out  32  fetch address (= pc_o)
- imem_ack_i  in  1  fetch done; imem_data_i valid this cycle
- imem_data_i  in  32  instruction word
- rf_rs1_o  out  5  register-file read address A
- rf_rs2_o  out  5  register-file read address B
- alu_ctrl_o  out  4  ALU op: 0000 add, 0001 sll, 0010 slt, 0011 sltu, 0100 xor, 0101 srl, 0110 or, 0111 and, 1000 sub, 1101 sra
- alu_b_sel_o  out  1  1 = ALU operand B is imm_o; 0 = rs2 data
- imm_o  out  32  sign-extended instr[31:20]
- alu_result_i  in  32  combinational ALU output
- rf_we_o  out  1  register-file write strobe, one cycle
- rf_rd_o  out  5  write address
- rf_wdata_o  out  32  registered ALU result
- pc_o  out  32  current PC
- illegal_o  out  1  one-cycle pulse on an unsupported instruction
- instret_o  out  32  retired-instruction count

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WB.
- Reset state is IDLE. Reset values:
  - pc_o = RESET_PC
  - instret_o = 0
  - all other outputs 0
  - instruction register = 0
- IDLE: if run_i, go to FETCH.
- FETCH: imem_req_o = 1 and imem_addr_o = pc_o, both stable while waiting. When imem_ack_i = 1, latch imem_data_i into the instruction register, drop the request on the next cycle and go to DECODE.
- DECODE:
  - rf_rs1_o = instr[19:15]; rf_rs2_o = instr[24:20]; rf_rd_o = instr[11:7]; imm_o = sign-extend instr[31:20].
  - alu_ctrl_o = {1'b0, funct3}, with two exceptions: funct3 000 on OP with funct7 = 0100000 gives 1000 (sub); funct3 101 with instr[30] = 1 gives 1101 (sra/srai).
  - alu_b_sel_o = 1 for OP-IMM (0010011), 0 for OP (0110011).
  - Legality:
    - OP requires funct7 = 0000000, or funct7 = 0100000 with funct3 000 or 101.
    - OP-IMM slli requires funct7 = 0; srli/srai require funct7 = 0000000 or 0100000.
    - Every other opcode is illegal.
  - Legal instructions go to EXEC. Illegal ones pulse illegal_o, add 4 to pc_o and go to WB with no write.
- EXEC: decode outputs held; register alu_result_i into rf_wdata_o; go to WB.
- WB:
  - Legal instruction: rf_we_o = 1 unless rd = 0; instret_o += 1 (wraps at 2^32); pc_o += 4 (wraps at 2^32).
  - Illegal instruction: no write, instret_o unchanged.
  - Next state is FETCH if run_i, else IDLE.
- Decode outputs (rs1, rs2, rd, imm, alu_ctrl, b_sel) hold their values until the next DECODE.
- run_i dropping in FETCH/DECODE/EXEC does not abort; the instruction completes.

## Timing
- Minimum throughput: 4 cycles per instruction (FETCH with same-cycle ack, DECODE, EXEC, WB) under continuous run_i.
- imem_ack_i is honoured only in FETCH and ignored elsewhere. An ack in the first FETCH cycle is legal.
- alu_result_i must settle within one cycle of the DECODE outputs; it is sampled at the end of EXEC.
- rf_we_o, rf_rd_o and rf_wdata_o are valid together for exactly the WB cycle.
- illegal_o is asserted for the DECODE cycle only.
- pc_o and instret_o update at the end of WB. pc_o also updates at the end of DECODE for an illegal instruction.
- Asserting res_i at any point immediately clears all outputs, including a pending request and an in-flight write, and forces IDLE. Operation restarts from RESET_PC.

## Test plan
- run_i = 1, ack immediate, 0x00500093 (addi x1,x0,5), alu_result_i = 5 → DECODE: rs1 = 0, imm_o = 5, b_sel = 1, alu_ctrl = 0000. WB: rf_we = 1, rd = 1, wdata = 5, pc_o = 4, instret = 1. The next imem_req comes 4 cycles after the first.
- 0x402081B3 (sub x3,x1,x2) → alu_ctrl = 1000, b_sel = 0, rs1 = 1, rs2 = 2, rd = 3, single-cycle rf_we.
- ack delayed 3 cycles → req held 4 cycles with addr constant, no other activity; 0x00000073 (ecall) → illegal_o pulses once, no rf_we, pc_o += 4, instret unchanged.
- 0x00500013 (addi x0,x0,5) → rf_we stays 0, instret += 1; srai with instr[30] = 1 → alu_ctrl = 1101.
- res_i asserted mid-EXEC → all outputs 0 and pc_o = RESET_PC the same cycle; after release with run_i = 1, the fetch resumes at RESET_PC.
- Preload pc near 0xFFFF_FFFC (RESET_PC parameter) and retire one instruction → pc_o wraps to 0; run_i = 0 at WB → IDLE with no req.

Source files
------------

// File: rtl/rv32_seq_ctrl.sv
// Multi-cycle RV32I OP/OP-IMM sequencer: FETCH/DECODE/EXEC/WB, 4 cycles minimum per instruction.
// Fetch waits on imem_ack_i with request and address held stable; run_i gates only new fetches.
module rv32_seq_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        res_i,
    input  logic        run_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic [4:0]  rf_rs1_o,
    output logic [4:0]  rf_rs2_o,
    output logic [3:0]  alu_ctrl_o,
    output logic        alu_b_sel_o,
    output logic [31:0] imm_o,
    input  logic [31:0] alu_result_i,
    output logic        rf_we_o,
    output logic [4:0]  rf_rd_o,
    output logic [31:0] rf_wdata_o,
    output logic [31:0] pc_o,
    output logic        illegal_o,
    output logic [31:0] instret_o
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] F7_ZERO   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instret_q, instret_d;
    logic [31:0] instr_q, instr_d;
    logic [4:0]  rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [31:0] imm_q, imm_d;
    logic [3:0]  alu_ctrl_q, alu_ctrl_d;
    logic        b_sel_q, b_sel_d;
    logic        legal_q, legal_d;
    logic [31:0] wdata_q, wdata_d;

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic        dec_legal, dec_b_sel, in_decode;
    logic [3:0]  dec_alu;
    logic [31:0] dec_imm;

    assign opcode    = instr_q[6:0];
    assign funct3    = instr_q[14:12];
    assign funct7    = instr_q[31:25];
    assign dec_imm   = {{20{instr_q[31]}}, instr_q[31:20]};
    assign dec_b_sel = (opcode == OPC_OPIMM);
    assign in_decode = (state_q == S_DECODE);

    always_comb begin
        dec_legal = 1'b0;
        case (opcode)
            OPC_OP: dec_legal = (funct7 == F7_ZERO) ||
                                ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            OPC_OPIMM: begin
                case (funct3)
                    3'b001:  dec_legal = (funct7 == F7_ZERO);
                    3'b101:  dec_legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
                    default: dec_legal = 1'b1;
                endcase
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // instr[30] selects arithmetic shift for both register and immediate forms
    always_comb begin
        dec_alu = {1'b0, funct3};
        if ((opcode == OPC_OP) && (funct3 == 3'b000) && (funct7 == F7_ALT))
            dec_alu = 4'b1000;
        if ((funct3 == 3'b101) && instr_q[30])
            dec_alu = 4'b1101;
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instret_d  = instret_q;
        instr_d    = instr_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        imm_d      = imm_q;
        alu_ctrl_d = alu_ctrl_q;
        b_sel_d    = b_sel_q;
        legal_d    = legal_q;
        wdata_d    = wdata_q;
        case (state_q)
            S_IDLE: if (run_i) state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ack_i) begin
                    instr_d = imem_data_i;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                rs1_d      = instr_q[19:15];
                rs2_d      = instr_q[24:20];
                rd_d       = instr_q[11:7];
                imm_d      = dec_imm;
                alu_ctrl_d = dec_alu;
                b_sel_d    = dec_b_sel;
                legal_d    = dec_legal;
                if (dec_legal) begin
                    state_d = S_EXEC;
                end else begin
                    pc_d    = pc_q + 32'd4;
                    state_d = S_WB;
                end
            end
            S_EXEC: begin
                wdata_d = alu_result_i;
                state_d = S_WB;
            end
            S_WB: begin
                if (legal_q) begin
                    pc_d      = pc_q + 32'd4;
                    instret_d = instret_q + 32'd1;
                end
                state_d = run_i ? S_FETCH : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge res_i) begin
        if (res_i) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            instret_q  <= 32'd0;
            instr_q    <= 32'd0;
            rs1_q      <= 5'd0;
            rs2_q      <= 5'd0;
            rd_q       <= 5'd0;
            imm_q      <= 32'd0;
            alu_ctrl_q <= 4'd0;
            b_sel_q    <= 1'b0;
            legal_q    <= 1'b0;
            wdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instret_q  <= instret_d;
            instr_q    <= instr_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            imm_q      <= imm_d;
            alu_ctrl_q <= alu_ctrl_d;
            b_sel_q    <= b_sel_d;
            legal_q    <= legal_d;
            wdata_q    <= wdata_d;
        end
    end

    // Decode fields are live from instr_q during DECODE, then held in registers
    assign rf_rs1_o    = in_decode ? instr_q[19:15] : rs1_q;
    assign rf_rs2_o    = in_decode ? instr_q[24:20] : rs2_q;
    assign rf_rd_o     = in_decode ? instr_q[11:7]  : rd_q;
    assign imm_o       = in_decode ? dec_imm        : imm_q;
    assign alu_ctrl_o  = in_decode ? dec_alu        : alu_ctrl_q;
    assign alu_b_sel_o = in_decode ? dec_b_sel      : b_sel_q;

    assign imem_req_o  = (state_q == S_FETCH);
    assign imem_addr_o = pc_q;
    assign pc_o        = pc_q;
    assign instret_o   = instret_q;
    assign illegal_o   = in_decode && !dec_legal;
    assign rf_we_o     = (state_q == S_WB) && legal_q && (rd_q != 5'd0);
    assign rf_wdata_o  = wdata_q;
endmodule

// File: tb/tb_rv32_seq_ctrl.sv
// Directed-vector bench for rv32_seq_ctrl, with a second instance reset near the top of the address space.
module tb_rv32_seq_ctrl;
    logic        clk = 1'b0;
    logic        res, run, run_w, ack;
    logic [31:0] data, alu;

    logic        req, bsel, we, ill;
    logic [31:0] addr, imm, wdata, pc, instret;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  actl;

    logic        w_req, w_bsel, w_we, w_ill;
    logic [31:0] w_addr, w_imm, w_wdata, w_pc, w_instret;
    logic [4:0]  w_rs1, w_rs2, w_rd;
    logic [3:0]  w_actl;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int first_req = 0;

    always #5 clk = ~clk;

    rv32_seq_ctrl #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk_i(clk), .res_i(res), .run_i(run),
        .imem_req_o(req), .imem_addr_o(addr), .imem_ack_i(ack), .imem_data_i(data),
        .rf_rs1_o(rs1), .rf_rs2_o(rs2), .alu_ctrl_o(actl), .alu_b_sel_o(bsel),
        .imm_o(imm), .alu_result_i(alu), .rf_we_o(we), .rf_rd_o(rd),
        .rf_wdata_o(wdata), .pc_o(pc), .illegal_o(ill), .instret_o(instret)
    );

    rv32_seq_ctrl #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk_i(clk), .res_i(res), .run_i(run_w),
        .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_ack_i(ack), .imem_data_i(data),
        .rf_rs1_o(w_rs1), .rf_rs2_o(w_rs2), .alu_ctrl_o(w_actl), .alu_b_sel_o(w_bsel),
        .imm_o(w_imm), .alu_result_i(alu), .rf_we_o(w_we), .rf_rd_o(w_rd),
        .rf_wdata_o(w_wdata), .pc_o(w_pc), .illegal_o(w_ill), .instret_o(w_instret)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        res = 1'b1; run = 1'b0; run_w = 1'b0; ack = 1'b0; data = 32'd0; alu = 32'd0;
        tick; tick;
        check("rst_req", req, 0);
        check("rst_pc", pc, 0);
        check("rst_instret", instret, 0);
        check("rst_we", we, 0);
        check("rst_ill", ill, 0);
        check("rst_imm", imm, 0);
        check("rst_wdata", wdata, 0);
        check("rst_wrap_pc", w_pc, 32'hFFFF_FFFC);
        res = 1'b0;
        tick;
        check("idle_no_req", req, 0);

        // addi x1,x0,5 with immediate ack
        run = 1'b1;
        tick;
        first_req = cyc;
        check("f1_req", req, 1);
        check("f1_addr", addr, 0);
        ack = 1'b1; data = 32'h0050_0093; alu = 32'd5;
        tick; ack = 1'b0;
        check("addi_req_drop", req, 0);
        check("addi_rs1", rs1, 0);
        check("addi_rd", rd, 1);
        check("addi_imm", imm, 5);
        check("addi_bsel", bsel, 1);
        check("addi_alu", actl, 4'b0000);
        check("addi_ill", ill, 0);
        tick;
        check("addi_exec_we", we, 0);
        tick;
        check("addi_wb_we", we, 1);
        check("addi_wb_rd", rd, 1);
        check("addi_wb_wdata", wdata, 5);
        check("addi_wb_pc", pc, 0);
        tick;
        check("f2_req", req, 1);
        check("f2_spacing", cyc - first_req, 4);
        check("addi_pc", pc, 4);
        check("addi_instret", instret, 1);
        check("f2_we_off", we, 0);

        // sub x3,x1,x2
        ack = 1'b1; data = 32'h4020_81B3; alu = 32'hFFFF_FFFE;
        tick; ack = 1'b0;
        check("sub_alu", actl, 4'b1000);
        check("sub_bsel", bsel, 0);
        check("sub_rs1", rs1, 1);
        check("sub_rs2", rs2, 2);
        check("sub_rd", rd, 3);
        tick; tick;
        check("sub_we", we, 1);
        check("sub_wdata", wdata, 32'hFFFF_FFFE);
        tick;
        check("sub_we_single", we, 0);
        check("sub_pc", pc, 8);
        check("sub_instret", instret, 2);

        // ecall with the ack delayed three cycles
        for (int i = 0; i < 4; i++) begin
            check("dly_req", req, 1);
            check("dly_addr", addr, 8);
            check("dly_we", we, 0);
            check("dly_ill", ill, 0);
            if (i < 3) tick;
        end
        ack = 1'b1; data = 32'h0000_0073;
        tick; ack = 1'b0;
        check("ecall_ill", ill, 1);
        check("ecall_pc_dec", pc, 8);
        tick;
        check("ecall_ill_once", ill, 0);
        check("ecall_pc", pc, 12);
        check("ecall_we", we, 0);
        tick;
        check("ecall_instret", instret, 2);
        check("ecall_req", req, 1);
        check("ecall_pc_hold", pc, 12);

        // addi x0,x0,5 retires without a write
        ack = 1'b1; data = 32'h0050_0013; alu = 32'd5;
        tick; ack = 1'b0;
        check("x0_rd", rd, 0);
        tick; tick;
        check("x0_we", we, 0);
        tick;
        check("x0_instret", instret, 3);
        check("x0_pc", pc, 16);

        // srai x5,x6,3
        ack = 1'b1; data = 32'h4033_5293; alu = 32'h0000_1234;
        tick; ack = 1'b0;
        check("srai_alu", actl, 4'b1101);
        check("srai_bsel", bsel, 1);
        check("srai_imm", imm, 32'h0000_0403);
        check("srai_rs1", rs1, 6);
        check("srai_ill", ill, 0);
        tick; tick;
        check("srai_we", we, 1);
        check("srai_rd", rd, 5);
        check("srai_wdata", wdata, 32'h0000_1234);
        tick;
        check("srai_instret", instret, 4);
        check("srai_pc", pc, 20);
        check("srai_hold_alu", actl, 4'b1101);
        check("srai_hold_rs1", rs1, 6);

        // reset asserted during EXEC
        ack = 1'b1; data = 32'h0050_0093; alu = 32'd5;
        tick; ack = 1'b0;
        tick;
        res = 1'b1;
        #1;
        check("mrst_req", req, 0);
        check("mrst_pc", pc, 0);
        check("mrst_instret", instret, 0);
        check("mrst_rd", rd, 0);
        check("mrst_imm", imm, 0);
        check("mrst_bsel", bsel, 0);
        check("mrst_wdata", wdata, 0);
        check("mrst_we", we, 0);
        tick;
        res = 1'b0;
        tick;
        check("resume_req", req, 1);
        check("resume_addr", addr, 0);

        // run low at WB returns to IDLE
        run = 1'b0;
        ack = 1'b1; data = 32'h0050_0093; alu = 32'd7;
        tick; ack = 1'b0;
        tick; tick;
        check("stop_we", we, 1);
        check("stop_wdata", wdata, 7);
        tick;
        check("stop_req", req, 0);
        check("stop_pc", pc, 4);
        check("stop_instret", instret, 1);
        tick;
        check("stop_idle_req", req, 0);

        // PC wrap on the second instance
        run_w = 1'b1;
        tick;
        check("wrap_req", w_req, 1);
        check("wrap_addr", w_addr, 32'hFFFF_FFFC);
        check("main_idle_req", req, 0);
        ack = 1'b1; data = 32'h0050_0093; alu = 32'd5;
        tick; ack = 1'b0; run_w = 1'b0;
        check("wrap_imm", w_imm, 5);
        tick; tick;
        check("wrap_we", w_we, 1);
        tick;
        check("wrap_pc", w_pc, 0);
        check("wrap_instret", w_instret, 1);
        check("wrap_idle_req", w_req, 0);
        check("main_pc_unchanged", pc, 4);
        check("main_instret_unchanged", instret, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
